// File: rtl/wordle_game_ctrl.sv
// Wordle game controller: seeds the target word index, lets the player edit
// one row of five letters with the buttons, hands the row to an external
// scorer, writes the scored row to the board and tracks win/lose.
module wordle_game_ctrl #(
    parameter int ROWS  = 6,
    parameter int WORDS = 100
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sub,
    input  logic        score_ack,
    input  logic [9:0]  score_colors,
    output logic [6:0]  word_index,
    output logic        score_req,
    output logic [24:0] guess,
    output logic        cell_we,
    output logic [2:0]  cell_row,
    output logic [2:0]  cell_col,
    output logic [6:0]  cell_data,
    output logic        row_we,
    output logic [34:0] row_data,
    output logic        board_clr,
    output logic [2:0]  cur_row,
    output logic [2:0]  cur_col,
    output logic [2:0]  state,
    output logic        win,
    output logic        lose
);

    typedef enum logic [2:0] {
        ST_SEED  = 3'd0,
        ST_EDIT  = 3'd1,
        ST_SCORE = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    localparam logic [2:0] LAST_ROW  = 3'(ROWS - 1);
    localparam logic [6:0] LAST_WORD = 7'(WORDS - 1);
    localparam logic [4:0] LETTER_A  = 5'd1;
    localparam logic [4:0] LETTER_Z  = 5'd26;

    state_t      state_reg;
    logic [6:0]  word_index_reg;
    logic [2:0]  cur_row_reg;
    logic [2:0]  cur_col_reg;
    logic [4:0]  letter_reg [0:4];
    logic        score_req_reg;
    logic        ack_done_reg;   // scored row written this cycle; move on next edge
    logic [9:0]  colors_reg;
    logic        cell_we_reg;
    logic [2:0]  cell_row_reg;
    logic [2:0]  cell_col_reg;
    logic [6:0]  cell_data_reg;
    logic        row_we_reg;
    logic [34:0] row_data_reg;
    logic        board_clr_reg;
    logic        clr_pending_reg; // blank the board on the first cycle out of reset
    logic        win_reg;
    logic        lose_reg;

    logic [4:0]  cur_letter;
    logic [4:0]  up_letter;
    logic [4:0]  down_letter;
    logic [4:0]  filled;
    logic        all_filled;
    logic [34:0] row_word;
    logic [24:0] guess_word;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_col
            assign filled[gi]              = (letter_reg[gi] != 5'd0);
            assign guess_word[gi*5 +: 5]   = letter_reg[gi];
            assign row_word[gi*7 +: 7]     = {score_colors[gi*2 +: 2], letter_reg[gi]};
        end
    endgenerate

    assign all_filled = &filled;
    assign cur_letter = letter_reg[cur_col_reg];

    // Letter wheel: up wraps Z (and blank) to A, down wraps A (and blank) to Z.
    always_comb begin
        up_letter   = cur_letter + 5'd1;
        down_letter = cur_letter - 5'd1;
        if (cur_letter == 5'd0 || cur_letter == LETTER_Z)
            up_letter = LETTER_A;
        if (cur_letter <= LETTER_A)
            down_letter = LETTER_Z;
    end

    // Game FSM with all outputs registered; strobes default low each cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg       <= ST_SEED;
            word_index_reg  <= 7'd0;
            cur_row_reg     <= 3'd0;
            cur_col_reg     <= 3'd0;
            for (int i = 0; i < 5; i++) letter_reg[i] <= 5'd0;
            score_req_reg   <= 1'b0;
            ack_done_reg    <= 1'b0;
            colors_reg      <= 10'd0;
            cell_we_reg     <= 1'b0;
            cell_row_reg    <= 3'd0;
            cell_col_reg    <= 3'd0;
            cell_data_reg   <= 7'd0;
            row_we_reg      <= 1'b0;
            row_data_reg    <= 35'd0;
            board_clr_reg   <= 1'b0;
            clr_pending_reg <= 1'b1;
            win_reg         <= 1'b0;
            lose_reg        <= 1'b0;
        end else begin
            cell_we_reg   <= 1'b0;
            row_we_reg    <= 1'b0;
            board_clr_reg <= 1'b0;
            if (clr_pending_reg) begin
                board_clr_reg   <= 1'b1;
                clr_pending_reg <= 1'b0;
            end

            case (state_reg)
                ST_SEED: begin
                    if (btn_sub)
                        state_reg <= ST_EDIT;
                    else if (word_index_reg == LAST_WORD)
                        word_index_reg <= 7'd0;
                    else
                        word_index_reg <= word_index_reg + 7'd1;
                end

                ST_EDIT: begin
                    if (btn_sub) begin
                        // A row with any blank letter cannot be submitted.
                        if (all_filled) begin
                            state_reg     <= ST_SCORE;
                            score_req_reg <= 1'b1;
                            ack_done_reg  <= 1'b0;
                        end
                    end else if (btn_up || btn_down) begin
                        letter_reg[cur_col_reg] <= btn_up ? up_letter : down_letter;
                        cell_we_reg   <= 1'b1;
                        cell_row_reg  <= cur_row_reg;
                        cell_col_reg  <= cur_col_reg;
                        cell_data_reg <= {2'b00, (btn_up ? up_letter : down_letter)};
                    end else if (btn_left) begin
                        if (cur_col_reg != 3'd0)
                            cur_col_reg <= cur_col_reg - 3'd1;
                    end else if (btn_right) begin
                        if (cur_col_reg != 3'd4)
                            cur_col_reg <= cur_col_reg + 3'd1;
                    end
                end

                ST_SCORE: begin
                    if (ack_done_reg) begin
                        // Row write happened with cur_row still pointing at it;
                        // now resolve the outcome.
                        ack_done_reg <= 1'b0;
                        if (colors_reg == 10'h3FF) begin
                            state_reg <= ST_WIN;
                            win_reg   <= 1'b1;
                        end else if (cur_row_reg == LAST_ROW) begin
                            state_reg <= ST_LOSE;
                            lose_reg  <= 1'b1;
                        end else begin
                            state_reg   <= ST_EDIT;
                            cur_row_reg <= cur_row_reg + 3'd1;
                            cur_col_reg <= 3'd0;
                            for (int i = 0; i < 5; i++) letter_reg[i] <= 5'd0;
                        end
                    end else if (score_ack) begin
                        colors_reg    <= score_colors;
                        score_req_reg <= 1'b0;
                        row_we_reg    <= 1'b1;
                        row_data_reg  <= row_word;
                        ack_done_reg  <= 1'b1;
                    end
                end

                ST_WIN, ST_LOSE: begin
                    if (btn_sub) begin
                        board_clr_reg <= 1'b1;
                        cur_row_reg   <= 3'd0;
                        cur_col_reg   <= 3'd0;
                        for (int i = 0; i < 5; i++) letter_reg[i] <= 5'd0;
                        win_reg       <= 1'b0;
                        lose_reg      <= 1'b0;
                        state_reg     <= ST_SEED;
                    end
                end

                default: begin
                    state_reg <= ST_SEED;
                end
            endcase
        end
    end

    assign word_index = word_index_reg;
    assign score_req  = score_req_reg;
    assign guess      = guess_word;
    assign cell_we    = cell_we_reg;
    assign cell_row   = cell_row_reg;
    assign cell_col   = cell_col_reg;
    assign cell_data  = cell_data_reg;
    assign row_we     = row_we_reg;
    assign row_data   = row_data_reg;
    assign board_clr  = board_clr_reg;
    assign cur_row    = cur_row_reg;
    assign cur_col    = cur_col_reg;
    assign state      = state_reg;
    assign win        = win_reg;
    assign lose       = lose_reg;

endmodule

// File: tb/tb_wordle_game_ctrl.sv
// Directed bench for wordle_game_ctrl: seeding, letter editing, submit
// gating, scoring handshake, win/lose paths and reset during scoring.
module tb_wordle_game_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        btn_up, btn_down, btn_left, btn_right, btn_sub;
    logic        score_ack;
    logic [9:0]  score_colors;
    logic [6:0]  word_index;
    logic        score_req;
    logic [24:0] guess;
    logic        cell_we;
    logic [2:0]  cell_row, cell_col;
    logic [6:0]  cell_data;
    logic        row_we;
    logic [34:0] row_data;
    logic        board_clr;
    logic [2:0]  cur_row, cur_col, state;
    logic        win, lose;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [4:0] B_SUB = 5'b10000, B_UP = 5'b01000, B_DN = 5'b00100,
                           B_LT  = 5'b00010, B_RT = 5'b00001;

    wordle_game_ctrl #(.ROWS(6), .WORDS(100)) dut (
        .clk(clk), .clr(clr),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sub(btn_sub),
        .score_ack(score_ack), .score_colors(score_colors),
        .word_index(word_index), .score_req(score_req), .guess(guess),
        .cell_we(cell_we), .cell_row(cell_row), .cell_col(cell_col),
        .cell_data(cell_data), .row_we(row_we), .row_data(row_data),
        .board_clr(board_clr), .cur_row(cur_row), .cur_col(cur_col),
        .state(state), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; returns 1 ns after the edge so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a button mask for exactly one sampling edge.
    task automatic press(input logic [4:0] m);
        {btn_sub, btn_up, btn_down, btn_left, btn_right} = m;
        tick();
        {btn_sub, btn_up, btn_down, btn_left, btn_right} = 5'b0;
    endtask

    // Fill all five columns with 'A' starting from column 0.
    task automatic fill_row_a();
        for (int c = 0; c < 5; c++) begin
            press(B_UP);
            press(B_RT);
        end
    endtask

    int req_cycles;

    initial begin
        clr = 1'b1;
        {btn_sub, btn_up, btn_down, btn_left, btn_right} = 5'b0;
        score_ack = 1'b0;
        score_colors = 10'd0;
        #2;
        tick();
        tick();

        // Reset state
        check_eq("rst_state", 64'(state), 64'(0));
        check_eq("rst_word_index", 64'(word_index), 64'(0));
        check_eq("rst_cursor", 64'({cur_row, cur_col}), 64'(0));
        check_eq("rst_win_lose", 64'({win, lose}), 64'(0));
        check_eq("rst_strobes", 64'({score_req, cell_we, row_we, board_clr}), 64'(0));

        // First cycle out of reset blanks the board; seed counter runs
        clr = 1'b0;
        tick();
        check_eq("board_clr_after_rst", 64'(board_clr), 64'(1));
        check_eq("seed_idx_1", 64'(word_index), 64'(1));
        tick();
        check_eq("board_clr_one_cycle", 64'(board_clr), 64'(0));
        for (int i = 0; i < 35; i++) tick();
        check_eq("seed_idx_37", 64'(word_index), 64'(37));
        press(B_SUB);
        check_eq("seed_freeze_idx", 64'(word_index), 64'(37));
        check_eq("seed_to_edit", 64'(state), 64'(1));
        tick();
        check_eq("idx_stays_frozen", 64'(word_index), 64'(37));

        // Left saturates at column 0
        press(B_LT);
        check_eq("left_sat_0", 64'(cur_col), 64'(0));
        check_eq("left_no_write", 64'(cell_we), 64'(0));

        // Down from blank -> Z, then up from Z -> A
        press(B_DN);
        check_eq("down_cell_we", 64'(cell_we), 64'(1));
        check_eq("down_cell_data", 64'(cell_data), 64'(26));
        check_eq("down_cell_pos", 64'({cell_row, cell_col}), 64'(0));
        tick();
        check_eq("cell_we_one_cycle", 64'(cell_we), 64'(0));
        press(B_UP);
        check_eq("up_cell_data", 64'(cell_data), 64'(1));

        // Columns 1 and 2 get B and C
        press(B_RT);
        press(B_UP); press(B_UP);
        check_eq("col1_cell_pos", 64'({cell_row, cell_col}), 64'({3'd0, 3'd1}));
        press(B_RT);
        press(B_UP); press(B_UP); press(B_UP);

        // Submit with blanks is ignored
        press(B_SUB);
        check_eq("sub_blank_state", 64'(state), 64'(1));
        check_eq("sub_blank_req", 64'(score_req), 64'(0));

        // Move to column 3, then up+right together: only the letter changes
        press(B_RT);
        press(B_UP | B_RT);
        check_eq("up_right_col", 64'(cur_col), 64'(3));
        check_eq("up_right_data", 64'(cell_data), 64'(1));
        press(B_UP); press(B_UP); press(B_UP);
        press(B_RT);
        for (int i = 0; i < 5; i++) press(B_UP);
        press(B_RT);
        check_eq("right_sat_4", 64'(cur_col), 64'(4));
        check_eq("guess_row0", 64'(guess), 64'({5'd5, 5'd4, 5'd3, 5'd2, 5'd1}));

        // Submit, ack after 7 cycles of score_req with all green
        press(B_SUB);
        check_eq("score_state", 64'(state), 64'(2));
        req_cycles = 0;
        if (score_req) req_cycles++;
        for (int i = 0; i < 6; i++) begin
            {btn_up, btn_right, btn_sub} = 3'b111;  // must be ignored while scoring
            tick();
            if (score_req) req_cycles++;
        end
        {btn_up, btn_right, btn_sub} = 3'b000;
        check_eq("guess_stable", 64'(guess), 64'({5'd5, 5'd4, 5'd3, 5'd2, 5'd1}));
        check_eq("row_we_before_ack", 64'(row_we), 64'(0));
        score_ack = 1'b1;
        score_colors = 10'h3FF;
        tick();
        score_ack = 1'b0;
        score_colors = 10'h000;
        check_eq("score_req_cycles", 64'(req_cycles), 64'(7));
        check_eq("req_drop_after_ack", 64'(score_req), 64'(0));
        check_eq("win_row_we", 64'(row_we), 64'(1));
        check_eq("win_row_data", 64'(row_data),
                 64'({7'h65, 7'h64, 7'h63, 7'h62, 7'h61}));
        check_eq("win_row_we_row", 64'(cur_row), 64'(0));
        check_eq("win_no_cell_we", 64'({cell_we, board_clr}), 64'(0));
        tick();
        check_eq("row_we_one_cycle", 64'(row_we), 64'(0));
        check_eq("win_state", 64'(state), 64'(3));
        check_eq("win_flag", 64'({win, lose}), 64'(2'b10));

        // Stray ack outside SCORE does nothing
        score_ack = 1'b1;
        tick();
        score_ack = 1'b0;
        check_eq("stray_ack_row_we", 64'(row_we), 64'(0));

        // New game from WIN
        press(B_SUB);
        check_eq("win_sub_board_clr", 64'(board_clr), 64'(1));
        check_eq("win_sub_state", 64'(state), 64'(0));
        check_eq("win_sub_flags", 64'({win, lose}), 64'(0));
        check_eq("win_sub_guess", 64'(guess), 64'(0));
        press(B_SUB);
        check_eq("game2_edit", 64'(state), 64'(1));

        // Six all-gray submissions -> LOSE
        for (int r = 0; r < 6; r++) begin
            fill_row_a();
            press(B_SUB);
            tick();
            score_ack = 1'b1;
            score_colors = 10'h155;
            tick();
            score_ack = 1'b0;
            check_eq($sformatf("gray_row_we_%0d", r), 64'(row_we), 64'(1));
            check_eq($sformatf("gray_row_idx_%0d", r), 64'(cur_row), 64'(r));
            check_eq($sformatf("gray_row_data_%0d", r), 64'(row_data), 64'({5{7'h21}}));
            tick();
            if (r < 5) begin
                check_eq($sformatf("adv_row_%0d", r), 64'({state, cur_row, cur_col}),
                         64'({3'd1, 3'(r + 1), 3'd0}));
                check_eq($sformatf("adv_guess_clr_%0d", r), 64'(guess), 64'(0));
            end
        end
        check_eq("lose_state", 64'(state), 64'(4));
        check_eq("lose_flag", 64'({win, lose}), 64'(2'b01));

        // Reset during SCORE
        press(B_SUB);
        check_eq("lose_sub_board_clr", 64'(board_clr), 64'(1));
        press(B_SUB);
        fill_row_a();
        press(B_SUB);
        check_eq("pre_clr_score", 64'({state, score_req}), 64'({3'd2, 1'b1}));
        clr = 1'b1;
        tick();
        check_eq("clr_score_req", 64'(score_req), 64'(0));
        check_eq("clr_state", 64'(state), 64'(0));
        clr = 1'b0;
        score_ack = 1'b1;
        score_colors = 10'h3FF;
        tick();
        score_ack = 1'b0;
        check_eq("late_ack_no_row_we", 64'(row_we), 64'(0));
        check_eq("late_ack_board_clr", 64'(board_clr), 64'(1));
        tick();
        check_eq("late_ack_still_seed", 64'({state, win}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wordle_game_ctrl.md
WORDLE_GAME_CTRL -- requirements
Module: wordle_game_ctrl

Interface
REQ-001 Parameter ROWS, default 6, number of guess rows; the column count is fixed at 5.
REQ-002 Parameter WORDS, default 100, size of the target word list.
REQ-003 clk  in  1  system clock (50 MHz); all logic on rising edge.
REQ-004 clr  in  1  reset, synchronous, active-high.
REQ-005 btn_up, btn_down, btn_left, btn_right, btn_sub  in  1 each  debounced single-cycle pulses.
REQ-006 score_ack  in  1  scorer has valid score_colors this cycle.
REQ-007 score_colors  in  10  2 bits per column, col0 in [1:0]; 01 gray, 10 yellow, 11 green.
REQ-008 word_index  out  7  target word index to the word ROM.
REQ-009 score_req  out  1  request scoring of guess.
REQ-010 guess  out  25  current row letters, 5 bits per column, col0 in [4:0].
REQ-011 cell_we, cell_row[2:0], cell_col[2:0], cell_data[6:0]  out  single-cell board write.
REQ-012 row_we  out  1; row_data  out  35  full-row board write at cur_row, cell = {color[1:0], letter[4:0]}.
REQ-013 board_clr  out  1  one-cycle pulse to blank the whole board.
REQ-014 cur_row  out  3; cur_col  out  3  cursor position.
REQ-015 state  out  3; win  out  1; lose  out  1.

Function
REQ-016 States SHALL be SEED=0, EDIT=1, SCORE=2, WIN=3, LOSE=4; no other state reachable, illegal codes go to SEED.
REQ-017 Letter code SHALL be 0 = blank, 1..26 = A..Z.
REQ-018 SEED: word_index increments every cycle and wraps from WORDS-1 to 0; btn_sub freezes it and enters EDIT.
REQ-019 EDIT: one button acted on per cycle, priority sub > up > down > left > right; lower-priority pulses that cycle are dropped.
REQ-020 btn_up: letter at cur_col goes 0 or 26 -> 1, else +1.
REQ-021 btn_down: letter goes 0 or 1 -> 26, else -1.
REQ-022 Up/down SHALL pulse cell_we for exactly the cycle after the button, with cell_row/col = cursor and cell_data = {2'b00, new letter}.
REQ-023 btn_left decrements cur_col, saturating at 0; btn_right increments, saturating at 4; no board write.
REQ-024 btn_sub in EDIT with any blank letter SHALL be ignored.
REQ-025 btn_sub in EDIT with all letters non-blank SHALL enter SCORE with score_req high the next cycle.
REQ-026 SCORE: score_req and guess SHALL be held stable until score_ack, and all buttons ignored.
REQ-027 On the score_ack cycle, capture score_colors and drop score_req next cycle.
REQ-028 In that same next cycle, pulse row_we with row_data = {colors, letters} per column.
REQ-029 After scoring, all five colors 11 -> WIN.
REQ-030 After scoring, not all green and cur_row = ROWS-1 -> LOSE.
REQ-031 After scoring, otherwise -> EDIT with cur_row+1, cur_col 0, and the letter buffer cleared.
REQ-032 score_ack outside SCORE SHALL be ignored.
REQ-033 WIN/LOSE: win (resp. lose) held high; btn_sub pulses board_clr, zeroes cursor and letter buffer, clears win/lose, and enters SEED.
REQ-034 cell_we, row_we, and board_clr SHALL be mutually exclusive and at most one cycle wide.

Reset
REQ-035 clr high at a clock edge SHALL force state SEED, word_index 0, cursor 0, letter buffer 0, win = lose = 0, and all strobes and score_req 0, from any state including mid-SCORE.
REQ-036 The first cycle after reset deassertion SHALL pulse board_clr.

Verification
REQ-037 Reset, 37 cycles in SEED, btn_sub -> word_index = 37, state = EDIT.
REQ-038 EDIT at col 0, btn_down -> cell_we next cycle, cell_data = 7'd26; then btn_up -> cell_data = 7'd1.
REQ-039 Fill row 0 with 1..5 and btn_sub; ack after 7 cycles with colors 10'h3FF -> score_req high 7 cycles, row_we with row_data color fields all 11, state = WIN.
REQ-040 Six submissions each acked with 10'h155 -> rows advance 0..5, then state = LOSE and lose = 1.
REQ-041 btn_sub with col 3 blank -> no score_req, state stays EDIT; btn_up + btn_right in the same cycle -> only the letter changes.
REQ-042 clr asserted during SCORE -> next cycle score_req = 0 and state = SEED; a later score_ack causes no row_we.
